// File: rtl/vga_fb_pkg.sv
// vga_fb_pkg: shared bank id type, default frame size and bank reset assignments.
package vga_fb_pkg;
   typedef logic [1:0] buf_id_t;
   localparam int FRAME_PIXELS = 61440;
   localparam buf_id_t WR_BUF_RST = 2'd0;
   localparam buf_id_t PEND_BUF_RST = 2'd1;
   localparam buf_id_t RD_BUF_RST = 2'd2;
endpackage

// File: rtl/fb_addr_counter.sv
// fb_addr_counter: pixel counter that either saturates at LIMIT or wraps from LIMIT to 0.
module fb_addr_counter #(
   parameter int LIMIT = 61440,
   parameter bit WRAP = 1'b0,
   parameter int W = $clog2(LIMIT + 1)
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         i_clear,
   input  logic         i_step,
   output logic [W-1:0] o_count,
   output logic         o_at_limit
);
   logic [W-1:0] r_count;
   assign o_count = r_count;
   assign o_at_limit = (r_count == W'(LIMIT));
   // clear wins over step so a same-cycle strobe still uses the old count
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) r_count <= '0;
      else if (i_clear) r_count <= '0;
      else if (i_step && !o_at_limit) r_count <= r_count + 1'b1;
      else if (i_step && WRAP) r_count <= '0;
endmodule

// File: rtl/frame_buffer_scheduler.sv
// frame_buffer_scheduler: triple-buffer bank rotation between PPU writer and VGA reader,
// with registered per-pixel write/read strobes and addresses.
module frame_buffer_scheduler #(
   parameter int FRAME_PIXELS = vga_fb_pkg::FRAME_PIXELS,
   parameter int ADDR_W = 16,
   parameter int DROP_W = 8
) (
   input  logic              vga_clock,
   input  logic              rst_n,
   input  logic              ppu_pixel_wr,
   input  logic              ppu_frame_end,
   input  logic              vga_rd,
   input  logic              vga_frame_end,
   output logic              wr_en,
   output logic [1:0]        wr_buf,
   output logic [ADDR_W-1:0] wr_addr,
   output logic              rd_en,
   output logic [1:0]        rd_buf,
   output logic [ADDR_W-1:0] rd_addr,
   output logic              frame_ready,
   output logic [DROP_W-1:0] dropped_frames,
   output logic              overrun,
   output logic              underrun
);
   import vga_fb_pkg::*;
   localparam int WCW = $clog2(FRAME_PIXELS + 1);
   localparam int RCW = $clog2(FRAME_PIXELS);
   buf_id_t r_wr_q, r_pend, r_rd_q, r_wr_buf, r_rd_buf;
   buf_id_t w_wr_p, w_pend_p, w_wr_n, w_pend_n, w_rd_n;
   logic r_ready, w_ready_p, w_vswap, w_ready_n, w_wr_full;
   logic r_wr_en, r_rd_en, r_ovr, r_unr;
   logic [ADDR_W-1:0] r_wr_addr, r_rd_addr;
   logic [DROP_W-1:0] r_drop;
   logic [WCW-1:0] w_wcnt;
   logic [RCW-1:0] w_rcnt;
   fb_addr_counter #(.LIMIT(FRAME_PIXELS), .WRAP(1'b0), .W(WCW)) u_wcnt (
      .clk(vga_clock), .rst_n(rst_n), .i_clear(ppu_frame_end), .i_step(ppu_pixel_wr),
      .o_count(w_wcnt), .o_at_limit(w_wr_full)
   );
   fb_addr_counter #(.LIMIT(FRAME_PIXELS - 1), .WRAP(1'b1), .W(RCW)) u_rcnt (
      .clk(vga_clock), .rst_n(rst_n), .i_clear(vga_frame_end), .i_step(vga_rd),
      .o_count(w_rcnt), .o_at_limit()
   );
   // PPU swap is applied first, then the VGA swap sees its result
   always_comb begin
      w_wr_p = ppu_frame_end ? r_pend : r_wr_q;
      w_pend_p = ppu_frame_end ? r_wr_q : r_pend;
      w_ready_p = ppu_frame_end | r_ready;
      w_vswap = vga_frame_end & w_ready_p;
      w_wr_n = w_wr_p;
      w_rd_n = w_vswap ? w_pend_p : r_rd_q;
      w_pend_n = w_vswap ? r_rd_q : w_pend_p;
      w_ready_n = w_ready_p & ~w_vswap;
   end
   always_ff @(posedge vga_clock or negedge rst_n)
      if (!rst_n) begin
         r_wr_q <= WR_BUF_RST;
         r_pend <= PEND_BUF_RST;
         r_rd_q <= RD_BUF_RST;
         r_ready <= 1'b0;
         r_wr_en <= 1'b0;
         r_wr_buf <= WR_BUF_RST;
         r_wr_addr <= '0;
         r_rd_en <= 1'b0;
         r_rd_buf <= RD_BUF_RST;
         r_rd_addr <= '0;
         r_drop <= '0;
         r_ovr <= 1'b0;
         r_unr <= 1'b0;
      end else begin
         r_wr_q <= w_wr_n;
         r_pend <= w_pend_n;
         r_rd_q <= w_rd_n;
         r_ready <= w_ready_n;
         r_wr_en <= ppu_pixel_wr & ~w_wr_full;
         r_wr_buf <= r_wr_q;
         if (ppu_pixel_wr && !w_wr_full) r_wr_addr <= ADDR_W'(w_wcnt);
         r_rd_en <= vga_rd;
         r_rd_buf <= r_rd_q;
         if (vga_rd) r_rd_addr <= ADDR_W'(w_rcnt);
         if (ppu_frame_end && r_ready && !(&r_drop)) r_drop <= r_drop + 1'b1;
         if (ppu_pixel_wr && w_wr_full) r_ovr <= 1'b1;
         if (ppu_frame_end && !w_wr_full) r_unr <= 1'b1;
      end
   assign wr_en = r_wr_en;
   assign wr_buf = r_wr_buf;
   assign wr_addr = r_wr_addr;
   assign rd_en = r_rd_en;
   assign rd_buf = r_rd_buf;
   assign rd_addr = r_rd_addr;
   assign frame_ready = r_ready;
   assign dropped_frames = r_drop;
   assign overrun = r_ovr;
   assign underrun = r_unr;
endmodule
